// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding and
// the bundle of per-stage control outputs.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        STALL_RUN      = 2'd0,
        STALL_DIV_WAIT = 2'd1,
        STALL_DIV_DONE = 2'd2
    } stall_state_e;

    typedef struct packed {
        logic if_stall;
        logic id_stall;
        logic exe_stall;
        logic id_flush;
        logic exe_flush;
        logic mem_flush;
        logic div_start;
        logic div_done;
    } stall_ctrl_t;

    localparam stall_ctrl_t CTRL_IDLE = '0;

    // Freeze IF, ID and EXE and feed bubbles into MEM while the divider runs.
    function automatic stall_ctrl_t div_hold_ctrl();
        stall_ctrl_t c;
        c           = CTRL_IDLE;
        c.if_stall  = 1'b1;
        c.id_stall  = 1'b1;
        c.exe_stall = 1'b1;
        c.mem_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use hazards, multi-cycle
// divide occupancy in EXE and ID redirects become per-stage hold/bubble controls.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 34,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             hzd_exe_to_id_A,
    input  logic             exe_is_div,
    input  logic             id_jump_taken,
    input  logic             stall_cnt_clr,
    output logic             if_stall,
    output logic             id_stall,
    output logic             exe_stall,
    output logic             id_flush,
    output logic             exe_flush,
    output logic             mem_flush,
    output logic             div_start,
    output logic             div_done,
    output logic [CNT_W-1:0] stall_count
);

    localparam int                DCNT_W   = $clog2(DIV_CYCLES);
    // The start cycle and the final zero-count cycle both stall, hence the -2.
    localparam logic [DCNT_W-1:0] DIV_LOAD = DCNT_W'(DIV_CYCLES - 2);

    stall_state_e      state_q;
    stall_state_e      state_d;
    logic [DCNT_W-1:0] div_cnt_q;
    logic [DCNT_W-1:0] div_cnt_d;
    stall_ctrl_t       ctrl;

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        ctrl      = CTRL_IDLE;
        case (state_q)
            STALL_RUN: begin
                if (exe_is_div) begin
                    ctrl           = div_hold_ctrl();
                    ctrl.div_start = 1'b1;
                    div_cnt_d      = DIV_LOAD;
                    state_d        = STALL_DIV_WAIT;
                end else if (hzd_exe_to_id_A) begin
                    ctrl.if_stall  = 1'b1;
                    ctrl.id_stall  = 1'b1;
                    ctrl.exe_flush = 1'b1;
                end else if (id_jump_taken) begin
                    ctrl.id_flush  = 1'b1;
                end
            end
            STALL_DIV_WAIT: begin
                ctrl = div_hold_ctrl();
                if (div_cnt_q == '0) begin
                    state_d = STALL_DIV_DONE;
                end else begin
                    div_cnt_d = div_cnt_q - DCNT_W'(1);
                end
            end
            STALL_DIV_DONE: begin
                // Redirect held in ID during the divide is honoured on release.
                ctrl.div_done = 1'b1;
                ctrl.id_flush = id_jump_taken;
                state_d       = STALL_RUN;
            end
            default: begin
                state_d = STALL_RUN;
            end
        endcase
        if (!nrst) begin
            ctrl = CTRL_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= STALL_RUN;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    assign if_stall  = ctrl.if_stall;
    assign id_stall  = ctrl.id_stall;
    assign exe_stall = ctrl.exe_stall;
    assign id_flush  = ctrl.id_flush;
    assign exe_flush = ctrl.exe_flush;
    assign mem_flush = ctrl.mem_flush;
    assign div_start = ctrl.div_start;
    assign div_done  = ctrl.div_done;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .nrst  (nrst),
        .inc   (ctrl.if_stall),
        .clr   (stall_cnt_clr),
        .count (stall_count)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl with DIV_CYCLES=4, CNT_W=3.
module tb_pipeline_stall_ctrl;

    localparam int DC  = 4;
    localparam int CW  = 3;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          nrst;
    logic          hzd_exe_to_id_A;
    logic          exe_is_div;
    logic          id_jump_taken;
    logic          stall_cnt_clr;
    logic          if_stall;
    logic          id_stall;
    logic          exe_stall;
    logic          id_flush;
    logic          exe_flush;
    logic          mem_flush;
    logic          div_start;
    logic          div_done;
    logic [CW-1:0] stall_count;

    int errors = 0;
    int checks = 0;

    // Model: mdl_age = -1 when no divide is in flight, otherwise the number of
    // cycles elapsed since the div_start cycle (1..DC stall/done phases).
    int mdl_age = -1;
    int mdl_cnt = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .DIV_CYCLES (DC),
        .CNT_W      (CW)
    ) dut (
        .clk             (clk),
        .nrst            (nrst),
        .hzd_exe_to_id_A (hzd_exe_to_id_A),
        .exe_is_div      (exe_is_div),
        .id_jump_taken   (id_jump_taken),
        .stall_cnt_clr   (stall_cnt_clr),
        .if_stall        (if_stall),
        .id_stall        (id_stall),
        .exe_stall       (exe_stall),
        .id_flush        (id_flush),
        .exe_flush       (exe_flush),
        .mem_flush       (mem_flush),
        .div_start       (div_start),
        .div_done        (div_done),
        .stall_count     (stall_count)
    );

    // Bit order: if, id, exe stall; id, exe, mem flush; div_start; div_done.
    function automatic logic [7:0] obs_vec();
        return {if_stall, id_stall, exe_stall, id_flush, exe_flush, mem_flush, div_start, div_done};
    endfunction

    function automatic logic [7:0] mdl_exp();
        logic [7:0] e;
        e = 8'h00;
        if (!nrst) return 8'h00;
        if (mdl_age < 0) begin
            if (exe_is_div)           e = 8'b1110_0110;
            else if (hzd_exe_to_id_A) e = 8'b1100_1000;
            else if (id_jump_taken)   e = 8'b0001_0000;
        end else if (mdl_age < DC) begin
            e = 8'b1110_0100;
        end else begin
            e = {3'b000, id_jump_taken, 3'b000, 1'b1};
        end
        return e;
    endfunction

    task automatic mdl_advance();
        logic [7:0] e;
        e = mdl_exp();
        if (!nrst) begin
            mdl_age = -1;
            mdl_cnt = 0;
        end else begin
            if (stall_cnt_clr)              mdl_cnt = 0;
            else if (e[7] && mdl_cnt < MAX) mdl_cnt = mdl_cnt + 1;
            if (mdl_age < 0) mdl_age = exe_is_div ? 1 : -1;
            else if (mdl_age < DC) mdl_age = mdl_age + 1;
            else mdl_age = -1;
        end
    endtask

    task automatic set_in(input logic r, input logic d, input logic h, input logic j, input logic c);
        nrst = r; exe_is_div = d; hzd_exe_to_id_A = h; id_jump_taken = j; stall_cnt_clr = c;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        mdl_advance();
        #1;
    endtask

    task automatic settle();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DC + 2 && mdl_age >= 0; i++) to_next();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        to_next();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        to_next();
        for (int i = 0; i < 3; i++) begin
            to_sample();
            checks++;
            if (obs_vec() !== 8'h00 || stall_count !== '0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d: got ctrl=%b cnt=%0d, want ctrl=00000000 cnt=0", i, obs_vec(), stall_count);
            end
            to_next();
        end
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        to_sample();
        checks++;
        if (obs_vec() !== 8'b1110_0110) begin
            errors++;
            $display("FAIL reset_release_div_start: got ctrl=%b, want 11100110", obs_vec());
        end
        to_next();
    endtask

    task automatic test_load_use();
        settle();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        to_sample();
        checks++;
        if (obs_vec() !== 8'b1100_1000) begin
            errors++;
            $display("FAIL load_use_same_cycle: got ctrl=%b, want 11001000", obs_vec());
        end
        to_next();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        to_sample();
        checks++;
        if (obs_vec() !== 8'h00 || stall_count !== CW'(1)) begin
            errors++;
            $display("FAIL load_use_after: got ctrl=%b cnt=%0d, want ctrl=00000000 cnt=1", obs_vec(), stall_count);
        end
        to_next();
    endtask

    task automatic test_div();
        logic [7:0] want;
        for (int j = 0; j < 2; j++) begin
            settle();
            for (int c = 0; c <= DC + 1; c++) begin
                set_in(1'b1, c <= DC, 1'b0, j[0], 1'b0);
                to_sample();
                if (c == 0)       want = 8'b1110_0110;
                else if (c < DC)  want = 8'b1110_0100;
                else if (c == DC) want = {3'b000, j[0], 4'b0001};
                else              want = {3'b000, j[0], 4'b0000};
                checks++;
                if (obs_vec() !== want) begin
                    errors++;
                    $display("FAIL div_seq jump=%0d cyc=%0d: got ctrl=%b, want %b", j, c, obs_vec(), want);
                end
                if (c >= DC) begin
                    checks++;
                    if (stall_count !== CW'(DC)) begin
                        errors++;
                        $display("FAIL div_stall_count jump=%0d cyc=%0d: got %0d, want %0d", j, c, stall_count, DC);
                    end
                end
                to_next();
            end
        end
    endtask

    task automatic test_back_to_back();
        settle();
        for (int c = 0; c < 8; c++) begin
            set_in(c != 7, 1'b1, 1'b0, 1'b0, 1'b0);
            to_sample();
            checks++;
            if (c == 7) begin
                if (obs_vec() !== 8'h00) begin
                    errors++;
                    $display("FAIL b2b_reset_mid_div: got ctrl=%b, want 00000000", obs_vec());
                end
            end else if (div_start !== (c == 0 || c == DC + 1) || obs_vec() !== mdl_exp()) begin
                errors++;
                $display("FAIL b2b_seq cyc=%0d: got ctrl=%b, want %b", c, obs_vec(), mdl_exp());
            end
            to_next();
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            to_sample();
            checks++;
            if (obs_vec() !== 8'h00 || stall_count !== '0) begin
                errors++;
                $display("FAIL b2b_after_abort cyc=%0d: got ctrl=%b cnt=%0d, want ctrl=00000000 cnt=0", c, obs_vec(), stall_count);
            end
            to_next();
        end
    endtask

    task automatic test_saturation();
        settle();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c <= 9; c++) begin
            if (c == 9) set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            to_sample();
            checks++;
            if (stall_count !== CW'((c < MAX) ? c : MAX) || if_stall !== 1'b1) begin
                errors++;
                $display("FAIL sat_count cyc=%0d: got cnt=%0d if_stall=%b, want cnt=%0d if_stall=1", c, stall_count, if_stall, (c < MAX) ? c : MAX);
            end
            to_next();
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        to_sample();
        checks++;
        if (stall_count !== '0) begin
            errors++;
            $display("FAIL sat_clear_wins: got cnt=%0d, want 0", stall_count);
        end
        to_next();
    endtask

    task automatic test_random();
        settle();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 99) >= 3, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 19) == 0);
            to_sample();
            checks++;
            if (obs_vec() !== mdl_exp() || stall_count !== CW'(mdl_cnt)) begin
                errors++;
                $display("FAIL random cyc=%0d: got ctrl=%b cnt=%0d, want ctrl=%b cnt=%0d", i, obs_vec(), stall_count, mdl_exp(), mdl_cnt);
            end
            to_next();
        end
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_load_use();
        test_div();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
